// File: rtl/alu_pkg.sv
// Purpose : shared ALUControl encodings and execute-unit FSM states.
// Latency : n/a (declarations only).
// Backpr. : n/a. The control decoder imports the same constants.
package alu_pkg;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SHL  = 3'b001;
  localparam logic [2:0] ALU_SUB  = 3'b010;
  localparam logic [2:0] ALU_RSVD = 3'b011;  // executes as ADD
  localparam logic [2:0] ALU_XOR  = 3'b100;
  localparam logic [2:0] ALU_SHR  = 3'b101;
  localparam logic [2:0] ALU_OR   = 3'b110;
  localparam logic [2:0] ALU_AND  = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  function automatic logic is_shift(input logic [2:0] op);
    return (op == ALU_SHL) || (op == ALU_SHR);
  endfunction

endpackage

// File: rtl/alu_exec_mc_if.sv
// Purpose : request/result bundle between issuer and the multi-cycle execute unit.
// Latency : n/a (wires only).
// Backpr. : issuer must see busy=0 for start to be taken.
// Ports   : start/alu_control/src_a/src_b from master; busy/done/result/zero/lt from slave.
interface alu_exec_mc_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [2:0]      alu_control;
  logic [XLEN-1:0] src_a;
  logic [XLEN-1:0] src_b;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;
  logic            zero;
  logic            lt;

  modport master (
    output start, alu_control, src_a, src_b,
    input  busy, done, result, zero, lt
  );

  modport slave (
    input  start, alu_control, src_a, src_b,
    output busy, done, result, zero, lt
  );
endinterface

// File: rtl/alu_logic_comb.sv
// Purpose : single-cycle ADD/SUB/XOR/OR/AND plus signed less-than.
// Latency : purely combinational.
// Backpr. : none.
// Ports   : op (ALUControl), a, b in; res, lt out. Shift codes pass a through.
module alu_logic_comb
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] res,
  output logic            lt
);

  always_comb begin
    res = a + b;
    case (op)
      ALU_ADD,
      ALU_RSVD: res = a + b;
      ALU_SUB:  res = a + ~b + {{(XLEN-1){1'b0}}, 1'b1};
      ALU_XOR:  res = a ^ b;
      ALU_OR:   res = a | b;
      ALU_AND:  res = a & b;
      // Shifts are sequenced by the parent; a shift of zero yields a.
      ALU_SHL,
      ALU_SHR:  res = a;
      default:  res = a + b;
    endcase
  end

  assign lt = $signed(a) < $signed(b);

endmodule

// File: rtl/alu_exec_mc.sv
// Purpose : multi-cycle integer execute unit; logic ops in one cycle, shifts one bit per cycle.
// Latency : done at accept+1 for non-shift/shamt=0, accept+shamt+1 for shifts.
// Backpr. : start ignored while busy (SHIFT); back-to-back accept allowed from DONE.
// Ports   : clk, rst_n (async active-low), bus (alu_exec_mc_if.slave).
module alu_exec_mc
  import alu_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int SHAMT_W = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  alu_exec_mc_if.slave  bus
);

  state_t               state_q, state_d;
  logic [XLEN-1:0]      work_q;
  logic [XLEN-1:0]      result_q;
  logic [2:0]           op_q;
  logic [SHAMT_W-1:0]   cnt_q;
  logic                 lt_pend_q;
  logic                 zero_q;
  logic                 lt_q;

  logic [XLEN-1:0]      logic_res;
  logic                 lt_c;
  logic [SHAMT_W-1:0]   shamt_in;
  logic                 accept;
  logic                 start_shift;
  logic                 last_shift;
  logic [XLEN-1:0]      shifted;

  alu_logic_comb #(.XLEN(XLEN)) u_logic (
    .op  (bus.alu_control),
    .a   (bus.src_a),
    .b   (bus.src_b),
    .res (logic_res),
    .lt  (lt_c)
  );

  assign shamt_in    = bus.src_b[SHAMT_W-1:0];
  assign accept      = bus.start && (state_q != ST_SHIFT);
  // A zero-length shift finishes like a logic op, with result = src_a.
  assign start_shift = accept && is_shift(bus.alu_control) && (shamt_in != '0);
  assign last_shift  = (state_q == ST_SHIFT) && (cnt_q == SHAMT_W'(1));
  assign shifted     = (op_q == ALU_SHL) ? {work_q[XLEN-2:0], 1'b0}
                                         : {1'b0, work_q[XLEN-1:1]};

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE,
      ST_DONE: begin
        if (accept) state_d = start_shift ? ST_SHIFT : ST_DONE;
        else        state_d = ST_IDLE;
      end
      ST_SHIFT: begin
        if (last_shift) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath: operand latches, shift engine, registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work_q    <= '0;
      result_q  <= '0;
      op_q      <= ALU_ADD;
      cnt_q     <= '0;
      lt_pend_q <= 1'b0;
      zero_q    <= 1'b0;
      lt_q      <= 1'b0;
    end else if (accept) begin
      op_q      <= bus.alu_control;
      cnt_q     <= shamt_in;
      work_q    <= bus.src_a;
      lt_pend_q <= lt_c;
      // Shifts keep the previous result visible until their own done.
      if (!start_shift) begin
        result_q <= logic_res;
        zero_q   <= (logic_res == '0);
        lt_q     <= lt_c;
      end
    end else if (state_q == ST_SHIFT) begin
      work_q <= shifted;
      cnt_q  <= cnt_q - SHAMT_W'(1);
      if (last_shift) begin
        result_q <= shifted;
        zero_q   <= (shifted == '0);
        lt_q     <= lt_pend_q;
      end
    end
  end

  assign bus.busy   = (state_q == ST_SHIFT);
  assign bus.done   = (state_q == ST_DONE);
  assign bus.result = result_q;
  assign bus.zero   = zero_q;
  assign bus.lt     = lt_q;

endmodule

// File: tb/tb_alu_exec_mc.sv
module tb_alu_exec_mc;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  alu_exec_mc_if #(.XLEN(32)) bus ();

  alu_exec_mc #(.XLEN(32), .SHAMT_W(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  bit check_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model (cycle-numbered completion) ----------
  int          m_cyc      = 0;
  bit          m_pend     = 1'b0;
  int          m_done_cyc = 0;
  logic [31:0] m_res      = '0;
  logic        m_lt       = 1'b0;
  logic        e_busy = 1'b0, e_done = 1'b0, e_zero = 1'b0, e_lt = 1'b0;
  logic [31:0] e_result = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pend   = 1'b0;
      e_busy   = 1'b0;
      e_done   = 1'b0;
      e_result = '0;
      e_zero   = 1'b0;
      e_lt     = 1'b0;
    end else begin
      logic        busy_now;
      logic [31:0] a, b;
      int          sh, lat;
      busy_now = m_pend && (m_cyc < m_done_cyc);
      if (bus.start && !busy_now) begin
        a   = bus.src_a;
        b   = bus.src_b;
        sh  = int'(b[4:0]);
        lat = 1;
        case (bus.alu_control)
          3'b000, 3'b011: m_res = a + b;
          3'b010:         m_res = a - b;
          3'b100:         m_res = a ^ b;
          3'b110:         m_res = a | b;
          3'b111:         m_res = a & b;
          3'b001: begin m_res = a << sh; if (sh != 0) lat = sh + 1; end
          default: begin m_res = a >> sh; if (sh != 0) lat = sh + 1; end
        endcase
        m_lt       = $signed(a) < $signed(b);
        m_pend     = 1'b1;
        m_done_cyc = m_cyc + lat;
      end
      m_cyc++;
      e_done = m_pend && (m_cyc == m_done_cyc);
      e_busy = m_pend && (m_cyc <  m_done_cyc);
      if (e_done) begin
        e_result = m_res;
        e_zero   = (m_res == 32'h0);
        e_lt     = m_lt;
      end
    end
  end

  // ---------------- per-cycle compare against the model -------------------
  always @(negedge clk) begin
    if (check_en) begin
      chk("cyc_busy",   {31'b0, bus.busy}, {31'b0, e_busy});
      chk("cyc_done",   {31'b0, bus.done}, {31'b0, e_done});
      chk("cyc_result", bus.result,        e_result);
      chk("cyc_zero",   {31'b0, bus.zero}, {31'b0, e_zero});
      chk("cyc_lt",     {31'b0, bus.lt},   {31'b0, e_lt});
    end
  end

  // ---------------- stimulus helpers --------------------------------------
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.start       = 1'b1;
    bus.alu_control = op;
    bus.src_a       = a;
    bus.src_b       = b;
    @(negedge clk);
    bus.start = 1'b0;
    bus.src_a = 32'hA5A5_A5A5;  // operands change after accept
    bus.src_b = 32'h5A5A_5A5A;
  endtask

  // Called at the negedge of cycle accept+lat0; returns latency of the done cycle.
  task automatic wait_done(input int lat0, input int limit, output int lat, output int busy_cnt);
    lat      = lat0;
    busy_cnt = 0;
    while (!bus.done && lat < limit) begin
      if (bus.busy) busy_cnt++;
      @(negedge clk);
      lat++;
    end
    if (!bus.done) begin
      n_cmp++;
      n_err++;
      $display("FAIL timeout: no done within %0d cycles", limit);
    end
  endtask

  int lat, bcnt, extra_done;

  initial begin
    #400_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start       = 1'b0;
    bus.alu_control = 3'b000;
    bus.src_a       = '0;
    bus.src_b       = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy",   {31'b0, bus.busy}, 32'd0);
    chk("rst_done",   {31'b0, bus.done}, 32'd0);
    chk("rst_result", bus.result,        32'h0);
    rst_n = 1'b1;
    check_en = 1'b1;
    @(negedge clk);

    // Back-to-back: ADD then SUB with start held high.
    bus.start = 1'b1; bus.alu_control = 3'b000; bus.src_a = 32'd5; bus.src_b = 32'd3;
    @(negedge clk);
    chk("b2b_add_done", {31'b0, bus.done}, 32'd1);
    chk("b2b_add_res",  bus.result,        32'h0000_0008);
    chk("b2b_add_zero", {31'b0, bus.zero}, 32'd0);
    bus.alu_control = 3'b010; bus.src_a = 32'd5; bus.src_b = 32'd5;
    @(negedge clk);
    bus.start = 1'b0;
    chk("b2b_sub_done", {31'b0, bus.done}, 32'd1);
    chk("b2b_sub_res",  bus.result,        32'h0000_0000);
    chk("b2b_sub_zero", {31'b0, bus.zero}, 32'd1);
    @(negedge clk);

    // BLT-style compare: -1 - 1.
    issue(3'b010, 32'hFFFF_FFFF, 32'h0000_0001);
    wait_done(1, 5, lat, bcnt);
    chk("blt_lat",  lat,               32'd1);
    chk("blt_res",  bus.result,        32'hFFFF_FFFE);
    chk("blt_lt",   {31'b0, bus.lt},   32'd1);
    chk("blt_zero", {31'b0, bus.zero}, 32'd0);

    // Reserved code executes as ADD.
    issue(3'b011, 32'h7FFF_FFFF, 32'h0000_0001);
    wait_done(1, 5, lat, bcnt);
    chk("rsvd_res", bus.result, 32'h8000_0000);

    // SHL 1 by 4.
    issue(3'b001, 32'h0000_0001, 32'd4);
    wait_done(1, 20, lat, bcnt);
    chk("shl4_lat",  lat,               32'd5);
    chk("shl4_busy", bcnt,              32'd4);
    chk("shl4_res",  bus.result,        32'h0000_0010);
    chk("shl4_bsy0", {31'b0, bus.busy}, 32'd0);

    // SHR 0x80000000 by 31 (maximum shift).
    issue(3'b101, 32'h8000_0000, 32'd31);
    wait_done(1, 60, lat, bcnt);
    chk("shr31_lat", lat,        32'd32);
    chk("shr31_res", bus.result, 32'h0000_0001);

    // SHL by 0 (src_b=0x20 has zero low bits) returns src_a.
    issue(3'b001, 32'hDEAD_BEEF, 32'h0000_0020);
    wait_done(1, 5, lat, bcnt);
    chk("shl0_lat", lat,        32'd1);
    chk("shl0_res", bus.result, 32'hDEAD_BEEF);

    // Start pulsed during SHIFT is ignored.
    issue(3'b101, 32'hF000_0000, 32'd8);
    @(negedge clk);
    bus.start = 1'b1; bus.alu_control = 3'b100; bus.src_a = 32'h1; bus.src_b = 32'h2;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(3, 30, lat, bcnt);
    chk("ign_lat", lat,        32'd9);
    chk("ign_res", bus.result, 32'h00F0_0000);
    extra_done = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.done) extra_done++;
    end
    chk("ign_single_done", extra_done, 32'd0);

    // Reset mid-shift: SHL by 20, reset in cycle 10.
    issue(3'b001, 32'h0000_0001, 32'd20);
    extra_done = 0;
    repeat (9) begin
      if (bus.done) extra_done++;
      @(negedge clk);
    end
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy",   {31'b0, bus.busy}, 32'd0);
    chk("arst_done",   {31'b0, bus.done}, 32'd0);
    chk("arst_result", bus.result,        32'h0);
    chk("arst_zero",   {31'b0, bus.zero}, 32'd0);
    chk("arst_lt",     {31'b0, bus.lt},   32'd0);
    chk("arst_nodone", extra_done,        32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (25) begin
      @(negedge clk);
      if (bus.done) extra_done++;
    end
    chk("arst_no_late_done", extra_done, 32'd0);

    // Fresh op after reset.
    issue(3'b111, 32'hFF00_FF00, 32'h0F0F_0F0F);
    wait_done(1, 5, lat, bcnt);
    chk("and_lat",  lat,               32'd1);
    chk("and_res",  bus.result,        32'h0F00_0F00);
    chk("and_zero", {31'b0, bus.zero}, 32'd0);
    chk("and_lt",   {31'b0, bus.lt},   32'd1);

    repeat (3) @(negedge clk);
    check_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
